data_memory_be: RTL and testbench
=================================

Name: data_memory_be

Overview:
Parametrised successor data memory for the RV32I pipeline MEM stage.
- Adds byte/halfword stores (SB/SH/SW) and sign/zero-extended loads (LB/LH/LW/LBU/LHU).
- Flags misaligned accesses.
- Keeps a sequential power-on clear and a handshaked UART debug port that is active only while the core is halted.
- Depth and debug address width are generic.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 4.
DBG_ADDR_W, 9, debug word-address width; index uses the low log2(DEPTH) bits.

Ports:
clk  input  1  system clock
reset  input  1  reset; asynchronous, active-high
address  input  32  CPU byte address
write_data  input  32  store data, right-aligned
mem_write  input  1  store enable
mem_read  input  1  load enable
funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
read_data  output  32  extended load result, combinational
misaligned  output  1  combinational flag for an illegal access on the current address/funct3
enable  input  1  core running; debug port is ignored while 1
dbg_req  input  1  debug request (level)
dbg_rw  input  1  1 = write, 0 = read
dbg_addr  input  DBG_ADDR_W  debug word address
dbg_wdata  input  32  debug write data
dbg_rdata  output  32  registered debug read data
dbg_ack  output  1  one-cycle acknowledge
init_done  output  1  high once the clear sweep has finished
word0  output  32  memory[0] for top-level display

Behaviour:
- Reset values:
  - FSM = INIT, clear pointer = 0, init_done = 0.
  - dbg_rdata = 0, dbg_ack = 0.
  - read_data = 0 while reset is high.
- FSM states:
  - INIT: writes 0 to memory[ptr] each cycle, ptr increments. Moves to RUN the cycle after ptr == DEPTH-1. Total DEPTH cycles.
  - RUN: normal operation; no exit except reset.
- In INIT:
  - CPU stores and debug requests are dropped.
  - dbg_ack stays 0.
  - read_data = 0.
- Word index = address[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
- Alignment (lane = address[1:0]):
  - Halfword requires address[0] = 0.
  - Word requires address[1:0] = 00.
  - misaligned is asserted only when mem_read or mem_write is high.
  - A misaligned store writes nothing; a misaligned load returns 0.
  - An undefined funct3 (011, 110, 111) is treated as misaligned.
- Stores (RUN, mem_write, aligned), committed on the clk edge:
  - SB writes byte lane address[1:0] with write_data[7:0].
  - SH writes lanes {address[1],0}+1 : {address[1],0} with write_data[15:0].
  - SW writes all 4 lanes.
  - Unselected bytes keep their value.
- Loads (RUN, mem_read), combinational:
  - The selected byte/halfword is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - mem_read = 0 gives 0.
- Read-during-write: a load to a word being stored in the same cycle returns the old contents.
- Debug port (RUN, enable = 0, dbg_req = 1):
  - Serviced in one cycle; dbg_ack pulses the next cycle.
  - A write stores dbg_wdata at memory[dbg_addr index].
  - A read loads dbg_rdata with that word (registered, valid when dbg_ack = 1).
- Debug re-arm: after an ack the port waits for dbg_req to drop before accepting again, so one request = one ack.
- Simultaneous CPU store and debug request: the CPU store wins. The debug request stays pending and is serviced the first cycle mem_write = 0.
- enable high: debug is ignored and dbg_ack = 0; a pending un-acked request waits.
- Reset mid-sweep or mid-debug restarts INIT from 0 and clears dbg_ack. Memory contents are undefined until the new sweep completes.

Optional Feature:
DMEM_BOUNDS_CHECK_EN
- Defined:
  - Adds output oob (1 bit, combinational): asserted when mem_read|mem_write and address[31:log2(DEPTH)+2] != 0.
  - An oob store is suppressed; an oob load returns 0.
  - Debug addresses with dbg_addr >= DEPTH are acked but write nothing and read 0.
- Undefined: no oob port; all addresses wrap modulo DEPTH as above.

Test Plan:
- Reset then idle DEPTH cycles -> init_done rises exactly at cycle DEPTH; a store issued at cycle 5 is lost (word 1 reads 0 afterwards).
- SW 0x11223344 @0x8; then LB @0xB -> 0x00000011; LH @0xA -> 0x00001122; LW @0x8 -> 0x11223344.
- SW 0x000080F0 @0x10; then LB @0x10 -> 0xFFFFFFF0; LBU @0x10 -> 0x000000F0; LH @0x10 -> 0xFFFF80F0; LHU @0x10 -> 0x000080F0.
- SB 0xAA @0x9 over 0x11223344 -> word = 0x1122AA44. SH @0x9 -> misaligned = 1, word unchanged. LW @0x6 -> misaligned = 1, read_data = 0.
- enable = 0, dbg write 0xDEADBEEF to addr 3 -> dbg_ack 1 cycle later; LW @0xC -> 0xDEADBEEF. Holding dbg_req high 5 cycles -> only one ack. Concurrent mem_write delays the ack by one cycle.
- Store @0x1004 with DEPTH = 1024 -> without the macro, word 1 is written; with DMEM_BOUNDS_CHECK_EN -> oob = 1, no write.

Source files
------------

// File: rtl/data_memory_be.sv
// data_memory_be: RV32I MEM-stage data memory with byte enables.
//   - SB/SH/SW stores with byte lanes, LB/LH/LW/LBU/LHU loads with sign/zero extension.
//   - Misaligned or undefined-funct3 accesses are flagged; such stores write nothing, loads return 0.
//   - After reset, a sweep clears the memory one word per cycle (DEPTH cycles), then the memory runs.
//   - A handshaked debug port (one request, one ack) is serviced only while the core is halted.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN adds the oob output, suppresses out-of-range
//   CPU accesses and makes debug addresses >= DEPTH inert (acked, no write, read 0).
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   address             CPU byte address (word index = address[log2(DEPTH)+1:2])
//   write_data          right-aligned store data
//   mem_write/mem_read  store / load enables
//   funct3              access type (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   read_data           combinational extended load result
//   misaligned          combinational illegal-access flag
//   enable              core running; debug port ignored while high
//   dbg_req/dbg_rw      debug request level / 1 = write
//   dbg_addr/dbg_wdata  debug word address / write data
//   dbg_rdata/dbg_ack   registered debug read data / one-cycle acknowledge
//   init_done           clear sweep finished
//   word0               memory[0] for display
//   oob                 (macro only) combinational out-of-range flag
module data_memory_be #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DBG_ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [2:0]            funct3,
  output logic [31:0]           read_data,
  output logic                  misaligned,
  input  logic                  enable,
  input  logic                  dbg_req,
  input  logic                  dbg_rw,
  input  logic [DBG_ADDR_W-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_ack,
  output logic                  init_done,
  output logic [31:0]           word0
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic                  oob
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned DBG_EXT_W = DBG_ADDR_W + AW;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [31:0]   mem [DEPTH];

  logic          run;
  logic          access;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          size_bad;
  logic          addr_oob_c;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          cpu_we;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  logic [DBG_EXT_W-1:0] dbg_ext;
  logic [AW-1:0]        dbg_idx;
  logic                 dbg_oob_c;
  logic                 dbg_armed;
  logic                 dbg_fire;
  logic                 dbg_wr;

  // FSM state register, clear pointer and init_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == S_RUN);
      if (state == S_INIT) begin
        clr_ptr <= clr_ptr + AW'(1);
      end
    end
  end

  // Next-state: leave INIT the cycle after the last word is cleared
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (clr_ptr == AW'(DEPTH - 1)) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
    endcase
  end

  assign run      = (state == S_RUN);
  assign access   = mem_read | mem_write;
  assign lane     = address[1:0];
  assign word_idx = address[AW+1:2];

  // Alignment check; undefined funct3 codes count as misaligned
  always_comb begin
    size_bad = 1'b1;
    case (funct3)
      3'b000, 3'b100: size_bad = 1'b0;
      3'b001, 3'b101: size_bad = address[0];
      3'b010:         size_bad = |address[1:0];
      default:        size_bad = 1'b1;
    endcase
  end

  assign misaligned = access & size_bad;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_oob_c = access & (|address[31:AW+2]);
  assign oob        = addr_oob_c;
`else
  assign addr_oob_c = 1'b0;
`endif

  // Store lane enables and data replicated across lanes
  always_comb begin
    st_be   = 4'b0000;
    st_data = write_data;
    case (funct3)
      3'b000: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{write_data[7:0]}};
      end
      3'b001: begin
        st_be   = address[1] ? 4'b1100 : 4'b0011;
        st_data = {2{write_data[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign cpu_we = run & mem_write & ~size_bad & ~addr_oob_c & (|st_be);

  // Load path: the array read happens before the edge, so a same-cycle store is not visible
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    read_data = '0;
    if (!reset && run && mem_read && !size_bad && !addr_oob_c) begin
      case (funct3)
        3'b000:  read_data = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  read_data = {{16{rd_half[15]}}, rd_half};
        3'b010:  read_data = rd_word;
        3'b100:  read_data = {24'h0, rd_byte};
        3'b101:  read_data = {16'h0, rd_half};
        default: read_data = '0;
      endcase
    end
  end

  // Debug address: zero-extend so narrow and wide DBG_ADDR_W both index cleanly
  assign dbg_ext = DBG_EXT_W'(dbg_addr);
  assign dbg_idx = dbg_ext[AW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign dbg_oob_c = (dbg_ext >= DBG_EXT_W'(DEPTH));
`else
  assign dbg_oob_c = 1'b0;
`endif

  // A CPU store owns the single write port; the debug request simply waits
  assign dbg_fire = run & ~enable & dbg_req & dbg_armed & ~mem_write;
  assign dbg_wr   = dbg_fire & dbg_rw & ~dbg_oob_c;

  // Debug handshake: ack one cycle after service, re-arm only once dbg_req drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_ack   <= 1'b0;
      dbg_armed <= 1'b1;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_fire;
      if (dbg_fire) begin
        dbg_armed <= 1'b0;
      end else if (!dbg_req) begin
        dbg_armed <= 1'b1;
      end
      if (dbg_fire && !dbg_rw) begin
        dbg_rdata <= dbg_oob_c ? 32'h0 : mem[dbg_idx];
      end
    end
  end

  // Single write port: clear sweep, then CPU store, then debug write
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[clr_ptr] <= '0;
    end else if (cpu_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end else if (dbg_wr) begin
      mem[dbg_idx] <= dbg_wdata;
    end
  end

  assign word0 = mem[0];

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be: directed cases plus randomized CPU/debug traffic
// checked against a byte-addressed behavioural model of the memory.
module tb_data_memory_be;

  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned DBG_ADDR_W = 9;

  logic                  clk;
  logic                  reset;
  logic [31:0]           address;
  logic [31:0]           write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [2:0]            funct3;
  logic [31:0]           read_data;
  logic                  misaligned;
  logic                  enable;
  logic                  dbg_req;
  logic                  dbg_rw;
  logic [DBG_ADDR_W-1:0] dbg_addr;
  logic [31:0]           dbg_wdata;
  logic [31:0]           dbg_rdata;
  logic                  dbg_ack;
  logic                  init_done;
  logic [31:0]           word0;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic                  oob;
`endif

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;

  data_memory_be #(.DEPTH(DEPTH), .DBG_ADDR_W(DBG_ADDR_W)) dut (
    .clk(clk), .reset(reset), .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .funct3(funct3),
    .read_data(read_data), .misaligned(misaligned), .enable(enable),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .init_done(init_done), .word0(word0)
`ifdef DMEM_BOUNDS_CHECK_EN
    , .oob(oob)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_bad(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic bit m_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return (a / (DEPTH * 4)) != 0;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] m_load(input bit rd, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w, v;
    int unsigned sh;
    if (!rd || m_bad(a, f) || m_oob(a)) return 32'h0;
    w  = ref_mem[m_idx(a)];
    sh = (a % 4) * 8;
    case (f)
      3'd0: begin v = (w >> sh) & 32'hFF;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd1: begin v = (w >> sh) & 32'hFFFF; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd2: return w;
      3'd4: return (w >> sh) & 32'hFF;
      3'd5: return (w >> sh) & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    int unsigned n;
    logic [31:0] ba, w;
    if (m_bad(a, f) || m_oob(a) || f > 3'd2) return;
    n = 1 << f;
    for (int unsigned k = 0; k < n; k++) begin
      ba = a + k;
      w  = ref_mem[m_idx(ba)];
      w[(ba % 4) * 8 +: 8] = 8'(d >> (8 * k));
      ref_mem[m_idx(ba)] = w;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  // ---------------- stimulus helpers ----------------
  // One CPU cycle: check combinational outputs against the model, then commit at the edge
  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, input string tag);
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    funct3     = f;
    write_data = d;
    #1;
    last_rd = read_data;
    check({tag, "_mis"}, 32'(misaligned), 32'((rd | wr) & m_bad(a, f)));
    check({tag, "_rd"}, read_data, m_load(rd, a, f));
`ifdef DMEM_BOUNDS_CHECK_EN
    check({tag, "_oob"}, 32'(oob), 32'((rd | wr) & m_oob(a)));
`endif
    step();
    if (wr) m_store(a, f, d);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic ld_const(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp,
                          input string tag);
    cpu_op(1'b1, 1'b0, a, f, 32'h0, tag);
    check({tag, "_k"}, last_rd, exp);
  endtask

  task automatic dbg_xfer(input bit rw, input logic [DBG_ADDR_W-1:0] a, input logic [31:0] wd,
                          input string tag);
    bit got;
    got       = 1'b0;
    enable    = 1'b0;
    dbg_req   = 1'b1;
    dbg_rw    = rw;
    dbg_addr  = a;
    dbg_wdata = wd;
    for (int c = 0; c < 8; c++) begin
      step();
      if (dbg_ack) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      if (rw) begin
        if (a < DEPTH) ref_mem[a % DEPTH] = wd;
      end else begin
        check({tag, "_rdata"}, dbg_rdata, (a < DEPTH) ? ref_mem[a % DEPTH] : 32'h0);
      end
    end
    dbg_req = 1'b0;
    step();
  endtask

  // Count DEPTH cycles after reset release; optionally inject a store and debug write at cycle 5
  task automatic run_sweep(input bit inject, input string tag);
    bit rd_bad, ack_bad;
    rd_bad   = 1'b0;
    ack_bad  = 1'b0;
    mem_read = 1'b1;
    funct3   = 3'b010;
    address  = 32'h4;
    for (int c = 1; c <= DEPTH; c++) begin
      if (inject && c == 5) begin
        mem_write  = 1'b1;
        write_data = 32'hCAFE_F00D;
        enable     = 1'b0;
        dbg_req    = 1'b1;
        dbg_rw     = 1'b1;
        dbg_addr   = 9'd2;
        dbg_wdata  = 32'h1234_5678;
      end
      step();
      if (inject && c == 5) mem_write = 1'b0;
      if (read_data !== 32'h0) rd_bad = 1'b1;
      if (dbg_ack) ack_bad = 1'b1;
      if (c == DEPTH - 1) check({tag, "_init_early"}, 32'(init_done), 32'd0);
      if (c == DEPTH)     check({tag, "_init_rise"}, 32'(init_done), 32'd1);
    end
    dbg_req  = 1'b0;
    mem_read = 1'b0;
    check({tag, "_init_rd0"}, 32'(rd_bad), 32'd0);
    check({tag, "_init_noack"}, 32'(ack_bad), 32'd0);
    m_clear();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned acks;
    bit stall_bad;
    logic [31:0] a, d;
    logic [2:0]  f;
    logic [2:0]  valid_f [5];

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    address = '0; write_data = '0; mem_write = 1'b0; mem_read = 1'b1; funct3 = 3'b010;
    enable = 1'b1; dbg_req = 1'b0; dbg_rw = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    valid_f[0] = 3'd0; valid_f[1] = 3'd1; valid_f[2] = 3'd2; valid_f[3] = 3'd4; valid_f[4] = 3'd5;
    m_clear();

    // Reset state
    step(); step(); step();
    check("rst_read_data", read_data, 32'h0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;

    // Sweep with a dropped store and dropped debug write
    run_sweep(1'b1, "sweep1");
    enable = 1'b1;
    ld_const(32'h4, 3'd2, 32'h0, "lost_store");
    ld_const(32'h8, 3'd2, 32'h0, "lost_dbg");

    // Byte/halfword extraction
    cpu_op(1'b0, 1'b1, 32'h8, 3'd2, 32'h1122_3344, "sw8");
    ld_const(32'hB, 3'd0, 32'h0000_0011, "lb_b");
    ld_const(32'hA, 3'd1, 32'h0000_1122, "lh_a");
    ld_const(32'h8, 3'd2, 32'h1122_3344, "lw_8");

    // Sign versus zero extension
    cpu_op(1'b0, 1'b1, 32'h10, 3'd2, 32'h0000_80F0, "sw10");
    ld_const(32'h10, 3'd0, 32'hFFFF_FFF0, "lb_10");
    ld_const(32'h10, 3'd4, 32'h0000_00F0, "lbu_10");
    ld_const(32'h10, 3'd1, 32'hFFFF_80F0, "lh_10");
    ld_const(32'h10, 3'd5, 32'h0000_80F0, "lhu_10");

    // Partial stores and misalignment
    cpu_op(1'b0, 1'b1, 32'h9, 3'd0, 32'h0000_00AA, "sb9");
    ld_const(32'h8, 3'd2, 32'h1122_AA44, "lw_after_sb");
    cpu_op(1'b0, 1'b1, 32'h9, 3'd1, 32'h0000_BEEF, "sh9_mis");
    ld_const(32'h8, 3'd2, 32'h1122_AA44, "lw_after_sh_mis");
    ld_const(32'h6, 3'd2, 32'h0, "lw6_mis");
    ld_const(32'h8, 3'd3, 32'h0, "f3_011");
    cpu_op(1'b0, 1'b0, 32'h6, 3'd2, 32'h0, "idle_nomis");
    cpu_op(1'b0, 1'b1, 32'hE, 3'd1, 32'hFFFF_5A5A, "sh_e");
    ld_const(32'hC, 3'd2, 32'h5A5A_0000, "lw_after_sh");

    // Read-during-write returns old data
    cpu_op(1'b1, 1'b1, 32'h8, 3'd2, 32'hFFFF_FFFF, "rdw");
    check("rdw_old", last_rd, 32'h1122_AA44);
    ld_const(32'h8, 3'd2, 32'hFFFF_FFFF, "rdw_new");

    // word0 display output
    cpu_op(1'b0, 1'b1, 32'h0, 3'd2, 32'h0000_A5A5, "sw0");
    check("word0", word0, 32'h0000_A5A5);

    // Debug write: one-cycle ack latency, one ack per held request
    enable = 1'b0; dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 9'd3; dbg_wdata = 32'hDEAD_BEEF;
    step();
    check("dbg_ack_lat", 32'(dbg_ack), 32'd1);
    ref_mem[3] = 32'hDEAD_BEEF;
    acks = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dbg_ack) acks++;
    end
    check("dbg_one_ack", acks, 32'd1);
    dbg_req = 1'b0;
    step();
    ld_const(32'hC, 3'd2, 32'hDEAD_BEEF, "lw_dbg");
    dbg_xfer(1'b0, 9'd3, 32'h0, "dbg_rd3");
    check("dbg_rd3_k", dbg_rdata, 32'hDEAD_BEEF);

    // CPU store delays a pending debug read by one cycle
    enable = 1'b0; dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 9'd8;
    mem_write = 1'b1; address = 32'h20; funct3 = 3'd2; write_data = 32'h55;
    step();
    check("dbg_stall", 32'(dbg_ack), 32'd0);
    m_store(32'h20, 3'd2, 32'h55);
    mem_write = 1'b0;
    step();
    check("dbg_after_stall", 32'(dbg_ack), 32'd1);
    check("dbg_after_stall_rdata", dbg_rdata, 32'h55);
    dbg_req = 1'b0;
    step();

    // enable high holds a request off
    enable = 1'b1; dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 9'd3;
    stall_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dbg_ack) stall_bad = 1'b1;
    end
    check("dbg_enable_hold", 32'(stall_bad), 32'd0);
    enable = 1'b0;
    step();
    check("dbg_enable_release", 32'(dbg_ack), 32'd1);
    check("dbg_enable_rdata", dbg_rdata, 32'hDEAD_BEEF);
    dbg_req = 1'b0;
    enable = 1'b1;
    step();

    // Address above DEPTH: wraps, or is blocked with the bounds check
    cpu_op(1'b0, 1'b1, 32'h1004, 3'd2, 32'h0000_0077, "sw1004");
`ifdef DMEM_BOUNDS_CHECK_EN
    ld_const(32'h4, 3'd2, 32'h0, "lw4_oob");
    ld_const(32'h1004, 3'd2, 32'h0, "lw1004_oob");
`else
    ld_const(32'h4, 3'd2, 32'h0000_0077, "lw4_wrap");
    ld_const(32'h1004, 3'd2, 32'h0000_0077, "lw1004_wrap");
`endif

    // Randomized CPU and debug traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8) begin
        a = 32'($urandom_range(0, 255));
        if (r == 7) a = a | ($urandom << 12);
        if ($urandom_range(0, 3) != 0) f = valid_f[$urandom_range(0, 4)];
        else f = 3'($urandom_range(0, 7));
        d = $urandom;
        cpu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, f, d, "rnd");
      end else begin
        dbg_xfer(1'($urandom_range(0, 1)), 9'($urandom_range(0, 63)), $urandom, "rnd_dbg");
      end
    end
    enable = 1'b1;
    for (int w = 0; w < 64; w++) cpu_op(1'b1, 1'b0, 32'(w * 4), 3'd2, 32'h0, "scan");
    check("word0_rnd", word0, ref_mem[0]);

    // Reset during a debug ack clears the handshake, then a mid-sweep reset restarts the sweep
    enable = 1'b0; dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 9'd3;
    step();
    check("pre_rst_ack", 32'(dbg_ack), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_ack", 32'(dbg_ack), 32'd0);
    check("rst_mid_rdata", dbg_rdata, 32'h0);
    check("rst_mid_init", 32'(init_done), 32'd0);
    dbg_req = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("mid_sweep_busy", 32'(init_done), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_sweep(1'b0, "sweep2");
    ld_const(32'hC, 3'd2, 32'h0, "post_sweep_lw");
    check("post_sweep_word0", word0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
